// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package mouse_pkg;

    // Packet assembly states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B0 = 3'd1,
        ST_WAIT_B1 = 3'd2,
        ST_WAIT_B2 = 3'd3,
        ST_UPDATE  = 3'd4
    } state_e;

    // Bit positions inside the PS/2 status byte.
    localparam int unsigned SYNC_BIT  = 3;
    localparam int unsigned XSIGN_BIT = 4;
    localparam int unsigned YSIGN_BIT = 5;
    localparam int unsigned XOVF_BIT  = 6;
    localparam int unsigned YOVF_BIT  = 7;

    // Receiver error codes (bit0 = parity, bit1 = stop).
    localparam logic [1:0] RX_ERR_NONE   = 2'b00;
    localparam logic [1:0] RX_ERR_PARITY = 2'b01;
    localparam logic [1:0] RX_ERR_STOP   = 2'b10;

    // Default screen extents.
    localparam int unsigned DEF_MAX_X = 159;
    localparam int unsigned DEF_MAX_Y = 119;

    // True when the receiver reported a clean byte.
    function automatic logic rx_byte_ok(input logic [1:0] err);
        return err == RX_ERR_NONE;
    endfunction

endpackage

// File: rtl/mouse_axis_accumulator.sv
// One axis of the absolute pointer: applies a 9-bit signed PS/2 delta and
// saturates the result to [0, MAX]. INVERT subtracts the delta (Y axis).
module mouse_axis_accumulator #(
    parameter int unsigned MAX    = 159,
    parameter int unsigned POS_W  = 8,
    parameter bit          INVERT = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       delta_byte_i,
    input  logic             sign_i,
    input  logic             ovf_i,
    input  logic             load_i,
    output logic [POS_W-1:0] pos_o
);

    // Wide enough for position +/- a full 9-bit delta without wrapping.
    localparam int unsigned SW = ((POS_W > 9) ? POS_W : 9) + 2;

    logic [POS_W-1:0]     pos_q, pos_d;
    logic signed [8:0]    delta;
    logic signed [SW-1:0] delta_ext, pos_ext, sum, max_s;

    // Build the signed delta, compute the new sum and clamp it.
    always_comb begin
        if (ovf_i) begin
            delta = sign_i ? 9'h100 : 9'h0FF;
        end else begin
            delta = {sign_i, delta_byte_i};
        end
        delta_ext = {{(SW-9){delta[8]}}, delta};
        pos_ext   = {{(SW-POS_W){1'b0}}, pos_q};
        max_s     = SW'(MAX);
        if (INVERT) begin
            sum = pos_ext - delta_ext;
        end else begin
            sum = pos_ext + delta_ext;
        end
        pos_d = pos_q;
        if (load_i) begin
            if (sum < 0) begin
                pos_d = '0;
            end else if (sum > max_s) begin
                pos_d = POS_W'(MAX);
            end else begin
                pos_d = sum[POS_W-1:0];
            end
        end
    end

    // Position register, reset to screen centre.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pos_q <= POS_W'(MAX >> 1);
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream and
// maintains a saturated absolute pointer position.
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int unsigned MAX_X          = DEF_MAX_X,
    parameter int unsigned MAX_Y          = DEF_MAX_Y,
    parameter int unsigned POS_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [7:0]       BYTE_IN,
    input  logic             BYTE_READY_IN,
    input  logic [1:0]       BYTE_ERROR_IN,
    output logic             READ_ENABLE,
    output logic [7:0]       MOUSE_STATUS,
    output logic [7:0]       MOUSE_DX,
    output logic [7:0]       MOUSE_DY,
    output logic [POS_W-1:0] MOUSE_X,
    output logic [POS_W-1:0] MOUSE_Y,
    output logic             PACKET_VALID,
    output logic             SYNC_ERROR
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      stat_lat_q, stat_lat_d;
    logic [7:0]      dx_lat_q, dx_lat_d;
    logic [7:0]      dy_lat_q, dy_lat_d;
    logic [7:0]      status_q, dx_q, dy_q;
    logic            rd_en_q, rd_en_d;
    logic            sync_q, sync_d;
    logic            valid_q;
    logic            load;
    logic            byte_ok;

    assign byte_ok = rx_byte_ok(BYTE_ERROR_IN);
    assign load    = (state_q == ST_UPDATE) && ENABLE;

    // Next-state, byte latching, timeout and error strobe decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stat_lat_d = stat_lat_q;
        dx_lat_d   = dx_lat_q;
        dy_lat_d   = dy_lat_q;
        sync_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_B0;
            end
            ST_WAIT_B0: begin
                if (BYTE_READY_IN) begin
                    if (!byte_ok || !BYTE_IN[SYNC_BIT]) begin
                        sync_d = 1'b1;
                    end else begin
                        stat_lat_d = BYTE_IN;
                        cnt_d      = '0;
                        state_d    = ST_WAIT_B1;
                    end
                end
            end
            ST_WAIT_B1, ST_WAIT_B2: begin
                cnt_d = cnt_q + 1'b1;
                // A byte in the timeout cycle takes precedence over the timeout.
                if (BYTE_READY_IN) begin
                    if (!byte_ok) begin
                        sync_d  = 1'b1;
                        state_d = ST_WAIT_B0;
                    end else if (state_q == ST_WAIT_B1) begin
                        dx_lat_d = BYTE_IN;
                        cnt_d    = '0;
                        state_d  = ST_WAIT_B2;
                    end else begin
                        dy_lat_d = BYTE_IN;
                        state_d  = ST_UPDATE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    sync_d  = 1'b1;
                    state_d = ST_WAIT_B0;
                end
            end
            ST_UPDATE: begin
                state_d = ST_WAIT_B0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!ENABLE) begin
            state_d = ST_IDLE;
            sync_d  = 1'b0;
        end
        rd_en_d = (state_d == ST_WAIT_B0) || (state_d == ST_WAIT_B1) ||
                  (state_d == ST_WAIT_B2);
    end

    // State, latches, registered strobes and published packet bytes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stat_lat_q <= '0;
            dx_lat_q   <= '0;
            dy_lat_q   <= '0;
            status_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            rd_en_q    <= 1'b0;
            sync_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stat_lat_q <= stat_lat_d;
            dx_lat_q   <= dx_lat_d;
            dy_lat_q   <= dy_lat_d;
            rd_en_q    <= rd_en_d;
            sync_q     <= sync_d;
            valid_q    <= load;
            if (load) begin
                status_q <= stat_lat_q;
                dx_q     <= dx_lat_q;
                dy_q     <= dy_lat_q;
            end
        end
    end

    mouse_axis_accumulator #(
        .MAX    (MAX_X),
        .POS_W  (POS_W),
        .INVERT (1'b0)
    ) u_acc_x (
        .CLK          (CLK),
        .RESET        (RESET),
        .delta_byte_i (dx_lat_q),
        .sign_i       (stat_lat_q[XSIGN_BIT]),
        .ovf_i        (stat_lat_q[XOVF_BIT]),
        .load_i       (load),
        .pos_o        (MOUSE_X)
    );

    mouse_axis_accumulator #(
        .MAX    (MAX_Y),
        .POS_W  (POS_W),
        .INVERT (1'b1)
    ) u_acc_y (
        .CLK          (CLK),
        .RESET        (RESET),
        .delta_byte_i (dy_lat_q),
        .sign_i       (stat_lat_q[YSIGN_BIT]),
        .ovf_i        (stat_lat_q[YOVF_BIT]),
        .load_i       (load),
        .pos_o        (MOUSE_Y)
    );

    assign READ_ENABLE  = rd_en_q;
    assign MOUSE_STATUS = status_q;
    assign MOUSE_DX     = dx_q;
    assign MOUSE_DY     = dy_q;
    assign PACKET_VALID = valid_q;
    assign SYNC_ERROR   = sync_q;

endmodule

// File: doc/mouse_packet_decoder.md
Name: mouse_packet_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver (MouseReceiver) and consumes its byte stream.
- Drives the receiver's READ_ENABLE and assembles standard 3-byte PS/2 mouse packets (status, dX, dY).
- Rejects bad or desynchronised bytes and times out stalled packets.
- Accumulates a saturated absolute pointer position for the display and peripheral logic, with a one-cycle strobe per accepted packet.

Parameters:
- MAX_X, 159, largest legal X coordinate; X saturates to [0, MAX_X].
- MAX_Y, 119, largest legal Y coordinate; Y saturates to [0, MAX_Y].
- POS_W, 8, width of the position outputs; must hold MAX_X and MAX_Y.
- TIMEOUT_CYCLES, 100000, maximum CLK cycles allowed between bytes 0→1 and 1→2 of one packet (2 ms at 50 MHz).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  stream mode active; driven by the mouse master after init completes.
- BYTE_IN  in  8  received byte from the receiver (BYTE_READ).
- BYTE_READY_IN  in  1  one-cycle pulse: BYTE_IN and BYTE_ERROR_IN are valid.
- BYTE_ERROR_IN  in  2  receiver error code: bit0 = parity, bit1 = stop; 00 = good.
- READ_ENABLE  out  1  enables the receiver.
- MOUSE_STATUS  out  8  last accepted status byte.
- MOUSE_DX  out  8  last accepted raw dX byte.
- MOUSE_DY  out  8  last accepted raw dY byte.
- MOUSE_X  out  POS_W  accumulated X position.
- MOUSE_Y  out  POS_W  accumulated Y position; 0 is the top of the screen.
- PACKET_VALID  out  1  one-cycle strobe: new packet and position outputs are visible.
- SYNC_ERROR  out  1  one-cycle strobe: byte or packet discarded.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, READ_ENABLE=0, MOUSE_STATUS/DX/DY=0, MOUSE_X=MAX_X>>1 (79), MOUSE_Y=MAX_Y>>1 (59), PACKET_VALID=0, SYNC_ERROR=0, timeout counter=0.
- Reset mid-packet discards all partial bytes.
- States: IDLE, WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
- ENABLE=0 in any state → IDLE next cycle; partial packet dropped, no strobe.
- IDLE → WAIT_B0 when ENABLE=1.
- READ_ENABLE is registered; high in WAIT_B0/B1/B2, low in IDLE and UPDATE.
- BYTE_READY_IN is ignored in IDLE and UPDATE, with no strobe.
- WAIT_B0 on BYTE_READY_IN:
  - error≠00 or BYTE_IN[3]=0 → stay, SYNC_ERROR pulse.
  - otherwise latch status → WAIT_B1.
- WAIT_B1 on BYTE_READY_IN:
  - error≠00 → WAIT_B0 + SYNC_ERROR.
  - otherwise latch dX → WAIT_B2.
- WAIT_B2: same rule as WAIT_B1; on a good byte, latch dY → UPDATE.
- Timeout counter:
  - Cleared on entry to WAIT_B1/WAIT_B2; increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES-1 with no byte → WAIT_B0 + SYNC_ERROR.
  - A byte arriving in the same cycle as the timeout wins.
- UPDATE lasts one cycle → WAIT_B0.
- Latency: the byte-2 BYTE_READY_IN pulse in cycle N gives UPDATE in N+1. In N+2, MOUSE_* hold the new values and PACKET_VALID=1 for that cycle only.
- Arithmetic, per axis:
  - Delta is 9-bit signed {sign, byte}: X sign = status[4], Y sign = status[5].
  - If the overflow bit is set (X: status[6], Y: status[7]), delta is forced to +255 (sign=0) or −256 (sign=1).
  - X_new = clamp(X + dX, 0, MAX_X).
  - Y_new = clamp(Y − dY, 0, MAX_Y), because PS/2 up is positive.
  - Intermediate sums use at least POS_W+2 signed bits; no wrap-around is permitted.
- MOUSE_STATUS/DX/DY update only in UPDATE; never on a discarded packet.

Decomposition:
- Package mouse_pkg:
  - state enum.
  - status bit indices: SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7.
  - receiver error code constants.
  - default MAX_X/MAX_Y.
- Sub-module mouse_axis_accumulator:
  - parameters MAX, POS_W, INVERT.
  - inputs: byte, sign, overflow, load strobe.
  - output: saturated position.
  - instantiated once for X (INVERT=0) and once for Y (INVERT=1).

Test Plan (TIMEOUT_CYCLES=64):
- Reset, ENABLE=1, bytes 0x08,0x05,0x03 (error 00) → READ_ENABLE=1 one cycle after ENABLE. PACKET_VALID single pulse two cycles after the third byte; X=84, Y=56, STATUS=0x08, DX=0x05, DY=0x03.
- Next packet 0x38,0xFB,0xFE (both negative) → X=79, Y=58. Then 0x48,0x00,0x00 (X overflow, positive) → X=159. Then 0x08,0x7F,0x00 → X stays 159.
- Byte 0x00 as byte 0 → SYNC_ERROR pulse, state WAIT_B0, no PACKET_VALID. Following valid packet 0x08,0x01,0x01 is accepted normally.
- Bytes 0x08, then 0x05 with BYTE_ERROR_IN=01 → SYNC_ERROR, outputs unchanged. Repeat with error=10 on byte 2 → same result.
- Bytes 0x08,0x05 then 70 idle cycles → SYNC_ERROR after 64 cycles. Next three bytes 0x08,0x02,0x00 → X increases by 2.
- ENABLE low mid-packet → READ_ENABLE=0, no strobes. RESET low after byte 1 → X=79, Y=59, all strobes 0 immediately (asynchronously).
